// File: rtl/ice_pkg.sv
// rtl/ice_pkg.sv - shared types and constants for the ICE buffer arbiter
package ice_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } ice_state_t;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_MAX_PKT = 64;
    localparam int DEF_FIFO_AW = 9;

    // Leading event-code bytes each requester class puts at the head of its packet
    localparam logic [7:0] EVT_MBUS_RX  = 8'h62;
    localparam logic [7:0] EVT_I2C_RX   = 8'h69;
    localparam logic [7:0] EVT_GPIO     = 8'h67;
    localparam logic [7:0] EVT_CMD_RESP = 8'h72;

endpackage

// File: rtl/ice_buffer_arbiter_if.sv
// rtl/ice_buffer_arbiter_if.sv - requester and byte-FIFO signal bundle
interface ice_buffer_arbiter_if
    import ice_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int FIFO_AW = DEF_FIFO_AW
);
    logic [NUM_REQ-1:0]   buf_req;
    logic [NUM_REQ-1:0]   buf_grant;
    logic [NUM_REQ*8-1:0] buf_data;
    logic [NUM_REQ-1:0]   buf_valid;
    logic [NUM_REQ-1:0]   cnt_inc;
    logic [7:0]           global_counter;
    logic [7:0]           fifo_wdata;
    logic                 fifo_wr;
    logic [FIFO_AW:0]     fifo_free;

    // master: requesters plus FIFO status; slave: the arbiter
    modport master (
        output buf_req, buf_data, buf_valid, cnt_inc, fifo_free,
        input  buf_grant, global_counter, fifo_wdata, fifo_wr
    );

    modport slave (
        input  buf_req, buf_data, buf_valid, cnt_inc, fifo_free,
        output buf_grant, global_counter, fifo_wdata, fifo_wr
    );

endinterface

// File: rtl/ice_rr_pick.sv
// rtl/ice_rr_pick.sv - combinational round-robin one-hot selector
module ice_rr_pick #(
    parameter  int N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last_winner,
    output logic [N-1:0]  grant_oh,
    output logic [IW-1:0] grant_idx,
    output logic          grant_any
);

    logic [IW-1:0] cand;

    // Search starts one past the previous winner so every requester gets a turn
    always_comb begin
        grant_oh  = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        cand      = '0;
        for (int off = 1; off <= N; off++) begin
            cand = IW'((int'(last_winner) + off) % N);
            if (!grant_any && req[cand]) begin
                grant_any      = 1'b1;
                grant_oh[cand] = 1'b1;
                grant_idx      = cand;
            end
        end
    end

endmodule

// File: rtl/ice_buffer_arbiter.sv
// rtl/ice_buffer_arbiter.sv - round-robin arbiter merging requester byte streams into one FIFO
module ice_buffer_arbiter
    import ice_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int MAX_PKT = DEF_MAX_PKT,
    parameter int FIFO_AW = DEF_FIFO_AW
) (
    input  logic                 clk,
    input  logic                 reset,
    ice_buffer_arbiter_if.slave  bus,
    input  logic                 overflow_clr,
    output logic                 pkt_overflow
);

    localparam int IW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW     = $clog2(MAX_PKT + 1);
    localparam int FREE_W = FIFO_AW + 1;

    ice_state_t         state;
    logic [IW-1:0]      winner;
    logic [IW-1:0]      last_winner;
    logic [CW-1:0]      byte_cnt;
    logic [NUM_REQ-1:0] grant_q;
    logic [7:0]         wdata_q;
    logic               wr_q;
    logic [7:0]         gcnt_q;
    logic               ovf_q;

    logic [NUM_REQ-1:0] pick_oh;
    logic [IW-1:0]      pick_idx;
    logic               pick_any;
    logic [7:0]         win_data;
    logic               win_valid;
    logic               win_req;
    logic               win_inc;
    logic               room_ok;

    ice_rr_pick #(.N(NUM_REQ)) u_pick (
        .req         (bus.buf_req),
        .last_winner (last_winner),
        .grant_oh    (pick_oh),
        .grant_idx   (pick_idx),
        .grant_any   (pick_any)
    );

    always_comb begin
        win_data  = '0;
        win_valid = 1'b0;
        win_req   = 1'b0;
        win_inc   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winner == IW'(i)) begin
                win_data  = bus.buf_data[i*8 +: 8];
                win_valid = bus.buf_valid[i];
                win_req   = bus.buf_req[i];
                win_inc   = bus.cnt_inc[i];
            end
        end
    end

    // A grant is only issued when a worst-case packet is guaranteed to fit
    assign room_ok = (bus.fifo_free >= FREE_W'(MAX_PKT));

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            winner      <= '0;
            last_winner <= IW'(NUM_REQ - 1);
            byte_cnt    <= '0;
            grant_q     <= '0;
            wdata_q     <= '0;
            wr_q        <= 1'b0;
            gcnt_q      <= '0;
            ovf_q       <= 1'b0;
        end else begin
            wr_q <= 1'b0;
            if (overflow_clr) begin
                ovf_q <= 1'b0;
            end
            case (state)
                ST_IDLE: begin
                    if (pick_any && room_ok) begin
                        winner   <= pick_idx;
                        grant_q  <= pick_oh;
                        byte_cnt <= '0;
                        state    <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    // A byte arriving with the request release is still forwarded
                    if (win_valid) begin
                        if (byte_cnt == CW'(MAX_PKT)) begin
                            ovf_q <= 1'b1;
                        end else begin
                            wr_q     <= 1'b1;
                            wdata_q  <= win_data;
                            byte_cnt <= byte_cnt + CW'(1);
                        end
                    end
                    if (win_inc) begin
                        gcnt_q <= gcnt_q + 8'd1;
                    end
                    if (!win_req) begin
                        grant_q     <= '0;
                        last_winner <= winner;
                        state       <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    grant_q <= '0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.buf_grant      = grant_q;
    assign bus.fifo_wdata     = wdata_q;
    assign bus.fifo_wr        = wr_q;
    assign bus.global_counter = gcnt_q;
    assign pkt_overflow       = ovf_q;

endmodule

// File: tb/tb_ice_buffer_arbiter.sv
// tb/tb_ice_buffer_arbiter.sv - directed self-checking bench for ice_buffer_arbiter
module tb_ice_buffer_arbiter;
    import ice_pkg::*;

    logic clk;
    logic reset;
    logic overflow_clr;
    logic pkt_overflow;

    int vectors;
    int miscompares;
    int wcount;
    logic [7:0] last_byte;
    logic [7:0] pkt1 [12];

    ice_buffer_arbiter_if #(.NUM_REQ(4), .FIFO_AW(9)) bus ();

    ice_buffer_arbiter #(.NUM_REQ(4), .MAX_PKT(64), .FIFO_AW(9)) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus.slave),
        .overflow_clr (overflow_clr),
        .pkt_overflow (pkt_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        reset        = 1'b1;
        overflow_clr = 1'b0;
        bus.buf_req   = '0;
        bus.buf_data  = '0;
        bus.buf_valid = '0;
        bus.cnt_inc   = '0;
        bus.fifo_free = 10'd512;
        pkt1[0] = EVT_MBUS_RX;
        for (int i = 1; i < 12; i++) pkt1[i] = 8'(i - 1);

        do_reset();
        check("rst_grant", 32'(bus.buf_grant), 32'h0);
        check("rst_wr", 32'(bus.fifo_wr), 32'h0);
        check("rst_wdata", 32'(bus.fifo_wdata), 32'h0);
        check("rst_gcnt", 32'(bus.global_counter), 32'h0);
        check("rst_ovf", 32'(pkt_overflow), 32'h0);

        // Single requester packet, last byte coincides with request release
        bus.buf_req = 4'b0001;
        tick();
        check("t1_grant0", 32'(bus.buf_grant), 32'h1);
        for (int i = 0; i < 12; i++) begin
            bus.buf_valid  = 4'b0001;
            bus.buf_data[7:0] = pkt1[i];
            if (i == 11) bus.buf_req = 4'b0000;
            tick();
            check($sformatf("t1_wr%0d", i), 32'(bus.fifo_wr), 32'h1);
            check($sformatf("t1_wdata%0d", i), 32'(bus.fifo_wdata), 32'(pkt1[i]));
        end
        bus.buf_valid = '0;
        check("t1_grant_drop", 32'(bus.buf_grant), 32'h0);
        tick();
        check("t1_wr_idle", 32'(bus.fifo_wr), 32'h0);

        // Round-robin between requesters 0 and 2
        do_reset();
        bus.buf_req = 4'b0101;
        tick();
        check("t2_first", 32'(bus.buf_grant), 32'h1);
        tick();
        check("t2_hold", 32'(bus.buf_grant), 32'h1);
        bus.buf_req = 4'b0100;
        tick();
        check("t2_gap_a", 32'(bus.buf_grant), 32'h0);
        tick();
        check("t2_gap_b", 32'(bus.buf_grant), 32'h0);
        tick();
        check("t2_second", 32'(bus.buf_grant), 32'h4);
        bus.buf_req = 4'b0000;
        tick();
        check("t2_rel2", 32'(bus.buf_grant), 32'h0);
        tick();
        bus.buf_req = 4'b0101;
        tick();
        check("t2_third", 32'(bus.buf_grant), 32'h1);
        bus.buf_req = 4'b0000;
        tick();
        tick();

        // Free-space threshold; bytes in IDLE are ignored
        bus.fifo_free = 10'd63;
        bus.buf_req   = 4'b0010;
        bus.buf_valid = 4'b0010;
        bus.buf_data[15:8] = 8'h33;
        tick();
        check("t3_nogrant_a", 32'(bus.buf_grant), 32'h0);
        check("t3_idle_wr", 32'(bus.fifo_wr), 32'h0);
        bus.buf_valid = '0;
        tick();
        check("t3_nogrant_b", 32'(bus.buf_grant), 32'h0);
        bus.fifo_free = 10'd64;
        tick();
        check("t3_grant1", 32'(bus.buf_grant), 32'h2);

        // 65-byte packet: last byte dropped, overflow sticky
        wcount    = 0;
        last_byte = '0;
        for (int i = 0; i < 65; i++) begin
            bus.buf_valid = 4'b0010;
            bus.buf_data[15:8] = 8'(i);
            tick();
            if (bus.fifo_wr === 1'b1) begin
                wcount++;
                last_byte = bus.fifo_wdata;
            end
        end
        bus.buf_valid = '0;
        check("t4_wcount", 32'(wcount), 32'd64);
        check("t4_lastbyte", 32'(last_byte), 32'h3f);
        check("t4_drop_wr", 32'(bus.fifo_wr), 32'h0);
        check("t4_ovf_set", 32'(pkt_overflow), 32'h1);
        check("t4_grant_kept", 32'(bus.buf_grant), 32'h2);
        tick();
        check("t4_ovf_sticky", 32'(pkt_overflow), 32'h1);
        overflow_clr = 1'b1;
        tick();
        check("t4_ovf_clr", 32'(pkt_overflow), 32'h0);
        bus.buf_valid = 4'b0010;
        tick();
        check("t4_set_wins", 32'(pkt_overflow), 32'h1);
        check("t4_set_wins_wr", 32'(bus.fifo_wr), 32'h0);
        overflow_clr  = 1'b0;
        bus.buf_valid = '0;
        tick();
        check("t4_ovf_hold", 32'(pkt_overflow), 32'h1);
        overflow_clr = 1'b1;
        tick();
        overflow_clr = 1'b0;
        check("t4_ovf_clr2", 32'(pkt_overflow), 32'h0);

        // Event counter: count to 0xFF, foreign increments ignored, wrap
        bus.cnt_inc = 4'b0010;
        for (int i = 0; i < 255; i++) tick();
        check("t5_gcnt_ff", 32'(bus.global_counter), 32'hff);
        bus.cnt_inc = 4'b0001;
        tick();
        check("t5_foreign", 32'(bus.global_counter), 32'hff);
        bus.cnt_inc = 4'b0011;
        tick();
        check("t5_wrap", 32'(bus.global_counter), 32'h00);
        bus.cnt_inc = 4'b0010;
        tick();
        check("t5_after_wrap", 32'(bus.global_counter), 32'h01);
        bus.cnt_inc = '0;

        // Reset in the middle of a granted packet
        bus.buf_valid = 4'b0010;
        bus.buf_data[15:8] = 8'h55;
        reset = 1'b1;
        tick();
        check("t6_rst_wr", 32'(bus.fifo_wr), 32'h0);
        check("t6_rst_grant", 32'(bus.buf_grant), 32'h0);
        check("t6_rst_gcnt", 32'(bus.global_counter), 32'h0);
        reset         = 1'b0;
        bus.buf_valid = '0;
        tick();
        check("t6_regrant", 32'(bus.buf_grant), 32'h2);
        bus.buf_valid = 4'b0010;
        bus.buf_data[15:8] = 8'ha5;
        tick();
        check("t6_wr", 32'(bus.fifo_wr), 32'h1);
        check("t6_wdata", 32'(bus.fifo_wdata), 32'ha5);
        bus.buf_valid = '0;
        bus.buf_req   = '0;
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
